// File: rtl/str_sender.sv
// Repeats a fixed byte string to a byte-wide transmitter, one sbyte_rdy/end_of_send
// handshake per byte, for a programmable number of passes.
module str_sender #(
    parameter int                 MSG_LEN   = 16,
    parameter logic [8*MSG_LEN-1:0] MESSAGE = {8'h00, "*", 8'h0a, 8'h0d, "!dlroW olleH"},
    parameter bit                 TERM_EN   = 1'b1,
    parameter logic [7:0]         TERM_CHAR = 8'h2A,
    parameter bit                 TERM_SEND = 1'b1,
    parameter int                 GAP       = 0,
    parameter int                 CNT_W     = 8
) (
    input  logic                       clk115,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           passes,
    input  logic                       abort,
    input  logic                       end_of_send,
    output logic [7:0]                 sbyte,
    output logic                       sbyte_rdy,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MSG_LEN):0]   char_idx,
    output logic [CNT_W-1:0]           pass_cnt
);

    localparam int IDX_W = $clog2(MSG_LEN) + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP, S_DRAIN} state_t;
    localparam state_t AFTER_BYTE = (GAP > 0) ? S_GAP : S_LOAD;

    state_t           state;
    logic [CNT_W-1:0] passes_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       msg_byte;
    logic             load_term;
    logic             byte_last;
    logic             more_passes;
    logic             pass_end;

    always_comb begin
        msg_byte = 8'h00;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (char_idx == IDX_W'(k)) msg_byte = MESSAGE[8*k +: 8];
        end
    end

    // A suppressed terminator ends the pass straight from LOAD; otherwise the
    // sent byte (held on sbyte) decides whether WAIT closes the pass.
    assign load_term   = TERM_EN && !TERM_SEND && (msg_byte == TERM_CHAR);
    assign byte_last   = (char_idx == IDX_W'(MSG_LEN - 1)) || (TERM_EN && (sbyte == TERM_CHAR));
    assign more_passes = ({1'b0, pass_cnt} + 1'b1) < {1'b0, passes_lat};
    assign pass_end    = !abort && (((state == S_LOAD) && load_term) ||
                                    ((state == S_WAIT) && end_of_send && byte_last));
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk115 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sbyte      <= 8'h00;
            sbyte_rdy  <= 1'b0;
            done       <= 1'b0;
            char_idx   <= '0;
            pass_cnt   <= '0;
            passes_lat <= '0;
            gap_cnt    <= '0;
        end else begin
            // NOTE: pulses default low each cycle; a branch below may raise them for one clock.
            sbyte_rdy <= 1'b0;
            done      <= 1'b0;
            if (state != S_GAP) gap_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        passes_lat <= (passes == '0) ? CNT_W'(1) : passes;
                        char_idx   <= '0;
                        pass_cnt   <= '0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (!load_term) begin
                        sbyte     <= msg_byte;
                        sbyte_rdy <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: state <= abort ? S_DRAIN : S_WAIT;
                S_WAIT: begin
                    if (end_of_send) begin
                        if (abort) begin
                            state <= S_IDLE;
                        end else if (!byte_last) begin
                            char_idx <= char_idx + 1'b1;
                            state    <= AFTER_BYTE;
                        end
                    end else if (abort) begin
                        state <= S_DRAIN;
                    end
                end
                S_GAP: begin
                    if (abort)                    state <= S_IDLE;
                    else if (gap_cnt == GAP_LAST) state <= S_LOAD;
                    else                          gap_cnt <= gap_cnt + 1'b1;
                end
                S_DRAIN: if (end_of_send) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (pass_end) begin
                if (more_passes) begin
                    pass_cnt <= pass_cnt + 1'b1;
                    char_idx <= '0;
                    state    <= AFTER_BYTE;
                end else begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_str_sender.sv
// Self-checking bench for str_sender: three configurations, transmitter models
// answering 10 cycles after each sbyte_rdy, and per-instance byte scoreboards.
module tb_str_sender;

    localparam int TIMEOUT = 2000;

    logic clk115 = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk115 = ~clk115;
    always @(posedge clk115) cyc <= cyc + 1;

    // ---------------- instance a: defaults ----------------
    logic       a_start = 1'b0, a_abort = 1'b0, a_inj = 1'b0, a_xeos = 1'b0;
    logic [7:0] a_passes = 8'd1;
    logic       a_eos;
    logic [7:0] a_sbyte;
    logic       a_rdy, a_busy, a_done;
    logic [4:0] a_idx;
    logic [7:0] a_pcnt;
    assign a_eos = a_xeos | a_inj;

    str_sender dut_a (
        .clk115(clk115), .rst(rst), .start(a_start), .passes(a_passes), .abort(a_abort),
        .end_of_send(a_eos), .sbyte(a_sbyte), .sbyte_rdy(a_rdy), .busy(a_busy),
        .done(a_done), .char_idx(a_idx), .pass_cnt(a_pcnt)
    );

    // ---------------- instance b: terminator suppressed ----------------
    logic       b_start = 1'b0, b_abort = 1'b0, b_xeos = 1'b0;
    logic [7:0] b_passes = 8'd3;
    logic [7:0] b_sbyte;
    logic       b_rdy, b_busy, b_done;
    logic [4:0] b_idx;
    logic [7:0] b_pcnt;

    str_sender #(.TERM_SEND(1'b0)) dut_b (
        .clk115(clk115), .rst(rst), .start(b_start), .passes(b_passes), .abort(b_abort),
        .end_of_send(b_xeos), .sbyte(b_sbyte), .sbyte_rdy(b_rdy), .busy(b_busy),
        .done(b_done), .char_idx(b_idx), .pass_cnt(b_pcnt)
    );

    // ---------------- instance c: short message, no terminator, gap ----------------
    logic       c_start = 1'b0, c_abort = 1'b0, c_xeos = 1'b0;
    logic [7:0] c_passes = 8'd1;
    logic [7:0] c_sbyte;
    logic       c_rdy, c_busy, c_done;
    logic [2:0] c_idx;
    logic [7:0] c_pcnt;

    str_sender #(.MSG_LEN(4), .MESSAGE("ABCD"), .TERM_EN(1'b0), .GAP(5)) dut_c (
        .clk115(clk115), .rst(rst), .start(c_start), .passes(c_passes), .abort(c_abort),
        .end_of_send(c_xeos), .sbyte(c_sbyte), .sbyte_rdy(c_rdy), .busy(c_busy),
        .done(c_done), .char_idx(c_idx), .pass_cnt(c_pcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk115);
        #1;
    endtask

    // Expected entries are {pass number, byte}.
    logic [15:0] a_q[$];
    logic [15:0] b_q[$];
    logic [15:0] c_q[$];
    int a_eos_cyc = 0, b_eos_cyc = 0, c_eos_cyc = 0;
    int a_rdy_cnt = 0, b_rdy_cnt = 0, c_rdy_cnt = 0;
    int a_done_cnt = 0, b_done_cnt = 0, c_done_cnt = 0;
    int b_star_cnt = 0;

    // Transmitter models: end_of_send exactly 10 cycles after each sbyte_rdy.
    always @(negedge clk115) begin : xmit_a
        logic [7:0] held;
        if (a_rdy) begin
            held = a_sbyte;
            repeat (10) @(posedge clk115);
            #1 a_xeos = 1'b1;
            a_eos_cyc = cyc;
            if (a_busy) check("a_sbyte_stable", a_sbyte, held);
            @(posedge clk115);
            #1 a_xeos = 1'b0;
        end
    end

    always @(negedge clk115) begin : xmit_b
        logic [7:0] held;
        if (b_rdy) begin
            held = b_sbyte;
            repeat (10) @(posedge clk115);
            #1 b_xeos = 1'b1;
            b_eos_cyc = cyc;
            check("b_sbyte_stable", b_sbyte, held);
            @(posedge clk115);
            #1 b_xeos = 1'b0;
        end
    end

    always @(negedge clk115) begin : xmit_c
        logic [7:0] held;
        if (c_rdy) begin
            held = c_sbyte;
            repeat (10) @(posedge clk115);
            #1 c_xeos = 1'b1;
            c_eos_cyc = cyc;
            check("c_sbyte_stable", c_sbyte, held);
            @(posedge clk115);
            #1 c_xeos = 1'b0;
        end
    end

    // Monitors: pop the scoreboard on every sbyte_rdy and time the handshake turnaround.
    always @(negedge clk115) begin : mon_a
        bit seen_idle = 1'b1;
        int last_rdy = 0;
        if (!a_busy) seen_idle = 1'b1;
        if (a_done) a_done_cnt++;
        if (a_rdy) begin
            a_rdy_cnt++;
            if (!seen_idle && a_eos_cyc > last_rdy) check("a_eos_to_rdy", cyc - a_eos_cyc, 2);
            last_rdy = cyc;
            seen_idle = 1'b0;
            check("a_rdy_expected", 32'(a_q.size() > 0), 1);
            if (a_q.size() > 0) check("a_byte", {a_pcnt, a_sbyte}, a_q.pop_front());
        end
    end

    always @(negedge clk115) begin : mon_b
        bit seen_idle = 1'b1;
        int last_rdy = 0;
        if (!b_busy) seen_idle = 1'b1;
        if (b_done) b_done_cnt++;
        if (b_rdy) begin
            b_rdy_cnt++;
            if (b_sbyte == 8'h2A) b_star_cnt++;
            // A new pass costs one extra LOAD cycle for the skipped terminator.
            if (!seen_idle && b_eos_cyc > last_rdy)
                check("b_eos_to_rdy", cyc - b_eos_cyc, (b_idx == 5'd0) ? 3 : 2);
            last_rdy = cyc;
            seen_idle = 1'b0;
            check("b_rdy_expected", 32'(b_q.size() > 0), 1);
            if (b_q.size() > 0) check("b_byte", {b_pcnt, b_sbyte}, b_q.pop_front());
        end
    end

    always @(negedge clk115) begin : mon_c
        bit seen_idle = 1'b1;
        int last_rdy = 0;
        if (!c_busy) seen_idle = 1'b1;
        if (c_done) c_done_cnt++;
        if (c_rdy) begin
            c_rdy_cnt++;
            // eos, 5 GAP cycles, LOAD, SEND.
            if (!seen_idle && c_eos_cyc > last_rdy) check("c_eos_to_rdy", cyc - c_eos_cyc, 7);
            last_rdy = cyc;
            seen_idle = 1'b0;
            check("c_rdy_expected", 32'(c_q.size() > 0), 1);
            if (c_q.size() > 0) check("c_byte", {c_pcnt, c_sbyte}, c_q.pop_front());
        end
    end

    initial begin
        string      hs;
        string      dcba;
        logic [7:0] hello [15];
        int         base_rdy;
        int         base_done;
        int         seen;

        hs = "Hello World!";
        for (int k = 0; k < 12; k++) hello[k] = hs[k];
        hello[12] = 8'h0d;
        hello[13] = 8'h0a;
        hello[14] = 8'h2a;
        dcba = "DCBA";

        // ---- reset state ----
        repeat (3) step();
        check("rst_sbyte", a_sbyte, 0);
        check("rst_rdy", a_rdy, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_idx", a_idx, 0);
        check("rst_pcnt", a_pcnt, 0);
        rst = 1'b0;
        step();

        // ---- default message, one pass ----
        for (int k = 0; k < 15; k++) a_q.push_back({8'd0, hello[k]});
        a_passes = 8'd1;
        a_start  = 1'b1;
        step();
        a_start = 1'b0;
        check("a_rdy_before_lat", a_rdy, 0);
        check("a_busy_load", a_busy, 1);
        step();
        check("a_first_rdy_lat", a_rdy, 1);
        for (int i = 0; i < TIMEOUT && a_done_cnt == 0; i++) step();
        repeat (5) step();
        check("a_done_cnt", a_done_cnt, 1);
        check("a_rdy_cnt", a_rdy_cnt, 15);
        check("a_q_empty", a_q.size(), 0);
        check("a_idle", a_busy, 0);

        // ---- terminator suppressed, three passes ----
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 14; k++) b_q.push_back({8'(p), hello[k]});
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int i = 0; i < 4 * TIMEOUT && b_done_cnt == 0; i++) step();
        repeat (5) step();
        check("b_done_cnt", b_done_cnt, 1);
        check("b_rdy_cnt", b_rdy_cnt, 42);
        check("b_q_empty", b_q.size(), 0);
        check("b_no_term_sent", b_star_cnt, 0);
        check("b_last_pass", b_pcnt, 2);
        check("b_idx_bound", 32'(b_idx <= 5'd15), 1);
        check("b_idle", b_busy, 0);

        // ---- short message with gap ----
        for (int k = 0; k < 4; k++) c_q.push_back({8'd0, dcba[k]});
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        for (int i = 0; i < TIMEOUT && c_done_cnt == 0; i++) step();
        repeat (5) step();
        check("c_done_cnt", c_done_cnt, 1);
        check("c_rdy_cnt", c_rdy_cnt, 4);
        check("c_q_empty", c_q.size(), 0);
        check("c_idx_last", c_idx, 3);

        // ---- abort one cycle after the 3rd sbyte_rdy ----
        base_rdy  = a_rdy_cnt;
        base_done = a_done_cnt;
        for (int k = 0; k < 3; k++) a_q.push_back({8'd0, hello[k]});
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        seen = 0;
        for (int i = 0; i < TIMEOUT && seen < 3; i++) begin
            step();
            if (a_rdy) seen++;
        end
        step();
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("a_drain_busy", a_busy, 1);
        for (int i = 0; i < 40 && a_busy; i++) step();
        check("a_drain_exit", cyc - a_eos_cyc, 1);
        repeat (20) step();
        check("a_abort_rdy_cnt", a_rdy_cnt - base_rdy, 3);
        check("a_abort_no_done", a_done_cnt - base_done, 0);
        check("a_abort_q_empty", a_q.size(), 0);

        // ---- passes=0, restart while busy, stray end_of_send in SEND ----
        base_rdy  = a_rdy_cnt;
        base_done = a_done_cnt;
        for (int k = 0; k < 15; k++) a_q.push_back({8'd0, hello[k]});
        a_passes = 8'd0;
        a_start  = 1'b1;
        step();
        a_start = 1'b0;
        step();
        check("a_send_cycle", a_rdy, 1);
        a_inj = 1'b1;
        step();
        a_inj = 1'b0;
        repeat (20) step();
        check("a_busy_restart", a_busy, 1);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int i = 0; i < TIMEOUT && a_done_cnt == base_done; i++) step();
        repeat (5) step();
        check("a_p0_rdy_cnt", a_rdy_cnt - base_rdy, 15);
        check("a_p0_done", a_done_cnt - base_done, 1);
        check("a_p0_q_empty", a_q.size(), 0);
        check("a_p0_pcnt", a_pcnt, 0);
        repeat (30) step();
        check("a_no_restart", a_busy, 0);

        // ---- reset during WAIT ----
        base_rdy  = a_rdy_cnt;
        base_done = a_done_cnt;
        for (int k = 0; k < 2; k++) a_q.push_back({8'd0, hello[k]});
        a_passes = 8'd1;
        a_start  = 1'b1;
        step();
        a_start = 1'b0;
        seen = 0;
        for (int i = 0; i < TIMEOUT && seen < 2; i++) begin
            step();
            if (a_rdy) seen++;
        end
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_sbyte", a_sbyte, 0);
        check("mid_rst_rdy", a_rdy, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_done", a_done, 0);
        check("mid_rst_idx", a_idx, 0);
        check("mid_rst_pcnt", a_pcnt, 0);
        step();
        rst = 1'b0;
        repeat (15) step();
        check("a_rst_rdy_cnt", a_rdy_cnt - base_rdy, 2);
        check("a_rst_no_done", a_done_cnt - base_done, 0);
        check("a_rst_q_empty", a_q.size(), 0);

        for (int k = 0; k < 15; k++) a_q.push_back({8'd0, hello[k]});
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int i = 0; i < TIMEOUT && a_done_cnt == base_done; i++) step();
        repeat (5) step();
        check("a_post_rst_rdy_cnt", a_rdy_cnt - base_rdy, 17);
        check("a_post_rst_done", a_done_cnt - base_done, 1);
        check("a_post_rst_q_empty", a_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
